key_debounce_ctrl: RTL and testbench

- Input-side companion to the LED output driver. It samples NKEYS active-low push-buttons on the 1 us tick clock.
- Per key it provides synchronisation, debounce, press/release/long-press event pulses and a debounced level.
- It also maintains a press-toggled control register that feeds the LED pattern logic as its mode/control input.

---
 rtl/key_debounce_ctrl.sv | 170 +++++++++++++++++
 tb/tb_key_debounce_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_ctrl
// Description : Per-key synchroniser, debouncer and event generator for
//               NKEYS active-low push-buttons sampled on a 1 us clock.
//               Each key produces a debounced level, one-cycle press,
//               release and long-press pulses. A press-toggled control
//               register is also provided.
// Ports       : CLK_1US    - 1 us system clock
//               SYS_RST    - asynchronous active-low reset
//               KEY_N      - raw button pins, 0 = pressed (asynchronous)
//               KeyState   - debounced level, 1 = pressed
//               KeyPress   - one-cycle pulse on accepted press
//               KeyRelease - one-cycle pulse on accepted release
//               KeyLong    - one-cycle pulse when hold reaches LONG_US
//               ControlReg - bit i toggles on each KeyPress[i]
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_ctrl #(
  parameter int NKEYS       = 4,
  parameter int DEBOUNCE_US = 20000,
  parameter int LONG_US     = 1000000
) (
  input  logic             CLK_1US,
  input  logic             SYS_RST,
  input  logic [NKEYS-1:0] KEY_N,
  output logic [NKEYS-1:0] KeyState,
  output logic [NKEYS-1:0] KeyPress,
  output logic [NKEYS-1:0] KeyRelease,
  output logic [NKEYS-1:0] KeyLong,
  output logic [NKEYS-1:0] ControlReg
);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [19:0] C_DB_LAST   = 20'(DEBOUNCE_US - 1);
  localparam logic [19:0] C_LONG_LAST = 20'(LONG_US - 1);

  // Two-flop synchroniser; reset value 1 means "released", so a key held
  // through reset is seen as a fresh press afterwards.
  logic [NKEYS-1:0] r_sync1;
  logic [NKEYS-1:0] r_sync2;

  always_ff @(posedge CLK_1US or negedge SYS_RST) begin
    if (!SYS_RST) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= KEY_N;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
    state_t      r_state;
    state_t      w_state_nxt;
    logic [19:0] r_cnt;
    logic [19:0] w_cnt_nxt;
    logic        r_long_done;
    logic        w_long_done_nxt;
    logic        w_press;
    logic        w_release;
    logic        w_long;
    logic        w_key_s;
    logic        r_level;
    logic        r_press;
    logic        r_release;
    logic        r_long;
    logic        r_ctrl;

    assign w_key_s = ~r_sync2[gi];

    always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_long_done_nxt = r_long_done;
      w_press         = 1'b0;
      w_release       = 1'b0;
      w_long          = 1'b0;
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (w_key_s) begin
            w_state_nxt = S_PRESS_WAIT;
          end
        end
        S_PRESS_WAIT: begin
          if (!w_key_s) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_DB_LAST) begin
            w_state_nxt = S_PRESSED;
            w_cnt_nxt   = '0;
            w_press     = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 20'd1;
          end
        end
        S_PRESSED: begin
          if (!w_key_s) begin
            w_state_nxt = S_RELEASE_WAIT;
            w_cnt_nxt   = '0;
          end else if (r_cnt != C_LONG_LAST) begin
            w_cnt_nxt = r_cnt + 20'd1;
          end
          // Counter saturates, so long_done alone guarantees a single pulse.
          if ((r_cnt == C_LONG_LAST) && !r_long_done) begin
            w_long          = 1'b1;
            w_long_done_nxt = 1'b1;
          end
        end
        S_RELEASE_WAIT: begin
          if (w_key_s) begin
            // Release bounce: back to held, long_done kept.
            w_state_nxt = S_PRESSED;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_DB_LAST) begin
            w_state_nxt     = S_IDLE;
            w_cnt_nxt       = '0;
            w_release       = 1'b1;
            w_long_done_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + 20'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_ff @(posedge CLK_1US or negedge SYS_RST) begin
      if (!SYS_RST) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_long_done <= 1'b0;
        r_level     <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_long      <= 1'b0;
        r_ctrl      <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_cnt       <= w_cnt_nxt;
        r_long_done <= w_long_done_nxt;
        r_level     <= (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASE_WAIT);
        r_press     <= w_press;
        r_release   <= w_release;
        r_long      <= w_long;
        if (w_press) begin
          r_ctrl <= ~r_ctrl;
        end
      end
    end

    assign KeyState[gi]   = r_level;
    assign KeyPress[gi]   = r_press;
    assign KeyRelease[gi] = r_release;
    assign KeyLong[gi]    = r_long;
    assign ControlReg[gi] = r_ctrl;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce_ctrl
// Description : Self-checking bench for key_debounce_ctrl. Expected pulse
//               events (cycle, kind, key) are queued when stimulus is
//               driven and popped as the DUT emits pulses; levels are
//               checked directly at fixed points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_ctrl;

  localparam int NKEYS = 4;
  localparam int D     = 20;
  localparam int L     = 100;
  // Pin changed just after a negedge whose cycle count is t: edge 0 is the
  // next posedge (count t+1), the pulse registers at edge D+2 and is seen
  // at the following negedge where the count is t+D+3.
  localparam int LAT   = D + 3;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  logic             clk;
  logic             rst_n;
  logic [NKEYS-1:0] key_n;
  logic [NKEYS-1:0] key_state;
  logic [NKEYS-1:0] key_press;
  logic [NKEYS-1:0] key_release;
  logic [NKEYS-1:0] key_long;
  logic [NKEYS-1:0] ctrl;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  logic [39:0] q[$];

  key_debounce_ctrl #(
    .NKEYS      (NKEYS),
    .DEBOUNCE_US(D),
    .LONG_US    (L)
  ) u_dut (
    .CLK_1US   (clk),
    .SYS_RST   (rst_n),
    .KEY_N     (key_n),
    .KeyState  (key_state),
    .KeyPress  (key_press),
    .KeyRelease(key_release),
    .KeyLong   (key_long),
    .ControlReg(ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int c, input int kind, input int key);
    q.push_back({32'(c), 4'(kind), 4'(key)});
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every observed pulse must match the head of the queue.
  logic [NKEYS-1:0] pv[3];
  logic [39:0]      obs_ev;
  logic [39:0]      exp_ev;
  always @(negedge clk) begin
    pv[K_PRESS]   = key_press;
    pv[K_RELEASE] = key_release;
    pv[K_LONG]    = key_long;
    for (int k = 0; k < NKEYS; k++) begin
      for (int e = 0; e < 3; e++) begin
        if (pv[e][k] !== 1'b0) begin
          obs_ev = {32'(cyc), 4'(e), 4'(k)};
          exp_ev = (q.size() == 0) ? '1 : q.pop_front();
          n_checks++;
          assert (obs_ev === exp_ev) else begin
            n_errors++;
            $error("FAIL sb_event observed cyc=%0d kind=%0d key=%0d expected cyc=%0d kind=%0d key=%0d",
                   obs_ev[39:8], obs_ev[7:4], obs_ev[3:0], exp_ev[39:8], exp_ev[7:4], exp_ev[3:0]);
          end
        end
      end
    end
  end

  int t0;

  initial begin
    rst_n = 1'b0;
    key_n = '1;
    wait_neg(3);
    chk("rst_state",   32'(key_state),   32'h0);
    chk("rst_press",   32'(key_press),   32'h0);
    chk("rst_release", 32'(key_release), 32'h0);
    chk("rst_long",    32'(key_long),    32'h0);
    chk("rst_ctrl",    32'(ctrl),        32'h0);
    rst_n = 1'b1;
    wait_neg(3);

    // 1. Clean press and release on key 0
    t0 = cyc; key_n[0] = 1'b0; push_ev(t0 + LAT, K_PRESS, 0);
    wait_neg(30);
    chk("t1_state", 32'(key_state), 32'h1);
    chk("t1_ctrl",  32'(ctrl),      32'h1);
    t0 = cyc; key_n[0] = 1'b1; push_ev(t0 + LAT, K_RELEASE, 0);
    wait_neg(30);
    chk("t1_state_rel", 32'(key_state), 32'h0);

    // 2. Bounce rejection on key 1
    key_n[1] = 1'b0; wait_neg(10);
    key_n[1] = 1'b1; wait_neg(5);
    chk("t2_no_press", 32'(ctrl), 32'h1);
    t0 = cyc; key_n[1] = 1'b0; push_ev(t0 + LAT, K_PRESS, 1);
    wait_neg(30);
    chk("t2_ctrl", 32'(ctrl), 32'h3);
    t0 = cyc; key_n[1] = 1'b1; push_ev(t0 + LAT, K_RELEASE, 1);
    wait_neg(30);

    // 3. Long press on key 2
    t0 = cyc; key_n[2] = 1'b0;
    push_ev(t0 + LAT, K_PRESS, 2);
    push_ev(t0 + LAT + L, K_LONG, 2);
    wait_neg(200);
    chk("t3_state_held", 32'(key_state), 32'h4);
    t0 = cyc; key_n[2] = 1'b1; push_ev(t0 + LAT, K_RELEASE, 2);
    wait_neg(30);
    chk("t3_state", 32'(key_state), 32'h0);
    chk("t3_ctrl",  32'(ctrl),      32'h7);

    // 4. Release bounce on key 3
    t0 = cyc; key_n[3] = 1'b0; push_ev(t0 + LAT, K_PRESS, 3);
    wait_neg(40);
    key_n[3] = 1'b1; wait_neg(10);
    chk("t4_state_bounce", 32'(key_state), 32'h8);
    key_n[3] = 1'b0; wait_neg(20);
    chk("t4_state_after", 32'(key_state), 32'h8);
    chk("t4_ctrl",        32'(ctrl),      32'hF);
    t0 = cyc; key_n[3] = 1'b1; push_ev(t0 + LAT, K_RELEASE, 3);
    wait_neg(30);
    chk("t4_state_rel", 32'(key_state), 32'h0);

    // 5. Simultaneous presses from a clean reset
    rst_n = 1'b0; wait_neg(2);
    chk("t5_rst_ctrl", 32'(ctrl), 32'h0);
    rst_n = 1'b1; wait_neg(2);
    for (int r = 0; r < 2; r++) begin
      t0 = cyc; key_n = '0;
      for (int k = 0; k < NKEYS; k++) push_ev(t0 + LAT, K_PRESS, k);
      wait_neg(30);
      chk("t5_state", 32'(key_state), 32'hF);
      chk("t5_ctrl",  32'(ctrl), (r == 0) ? 32'hF : 32'h0);
      t0 = cyc; key_n = '1;
      for (int k = 0; k < NKEYS; k++) push_ev(t0 + LAT, K_RELEASE, k);
      wait_neg(30);
    end

    // 6. Asynchronous reset in the middle of a press qualification
    t0 = cyc; key_n[3] = 1'b0; push_ev(t0 + LAT, K_PRESS, 3);
    wait_neg(30);
    chk("t6_pre_state", 32'(key_state), 32'h8);
    chk("t6_pre_ctrl",  32'(ctrl),      32'h8);
    key_n[0] = 1'b0;
    wait_neg(12);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_state", 32'(key_state), 32'h0);
    chk("t6_async_ctrl",  32'(ctrl),      32'h0);
    wait_neg(3);
    t0 = cyc; rst_n = 1'b1;
    push_ev(t0 + LAT, K_PRESS, 0);
    push_ev(t0 + LAT, K_PRESS, 3);
    wait_neg(30);
    chk("t6_post_state", 32'(key_state), 32'h9);
    chk("t6_post_ctrl",  32'(ctrl),      32'h9);
    t0 = cyc; key_n = '1;
    push_ev(t0 + LAT, K_RELEASE, 0);
    push_ev(t0 + LAT, K_RELEASE, 3);
    wait_neg(30);

    chk("sb_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
